// File: rtl/iot_pkg.sv
// Shared definitions for the iot_tx word-to-byte serialiser.
// The optional checksum byte (macro IOT_TX_CHKSUM_EN) uses word_xor below.
package iot_pkg;
    localparam int DW = 128;
    localparam int BW = 8;
    localparam int BYTES_PER_WORD = DW / BW;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CHK
    } state_t;

    function automatic logic [BW-1:0] word_byte(input logic [DW-1:0] word, input logic [3:0] k);
        return word[k*BW +: BW];
    endfunction

    function automatic logic [BW-1:0] word_xor(input logic [DW-1:0] word);
        logic [BW-1:0] acc;
        acc = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            acc = acc ^ word[i*BW +: BW];
        end
        return acc;
    endfunction
endpackage

// File: rtl/iot_tx_fifo.sv
// Two-entry word FIFO feeding the serialiser; exposes the head and the
// entry behind it so the next frame can start without a gap.
module iot_tx_fifo
    import iot_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [DW-1:0] second,
    output logic [1:0]    count
);
    logic [DW-1:0] mem [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head   = mem[rd_ptr];
    assign second = mem[~rd_ptr];
endmodule

// File: rtl/iot_tx.sv
// Serialises 128-bit words into LSB-first byte frames with downstream stall.
// Define IOT_TX_CHKSUM_EN to append an XOR checksum byte to every frame.
module iot_tx
    import iot_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    output logic          din_ready,
    input  logic          busy,
    output logic          out_en,
    output logic [BW-1:0] tx_data,
    output logic          tx_last,
    output logic [7:0]    words_sent
);
    localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_WORD - 1);
`ifdef IOT_TX_CHKSUM_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    state_t        state;
    state_t        next_state;
    logic [3:0]    idx;
    logic [3:0]    next_idx;
    logic          next_out_en;
    logic [BW-1:0] next_data;
    logic          next_last;
    logic          push;
    logic          pop;
    logic          transfer;
    logic [DW-1:0] head;
    logic [DW-1:0] second;
    logic [1:0]    count;
    logic          follow_valid;
    logic [DW-1:0] follow_word;

    assign din_ready = (count != 2'd2);
    assign push      = din_valid & din_ready;
    assign transfer  = out_en & ~busy;

    iot_tx_fifo u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    (din),
        .head   (head),
        .second (second),
        .count  (count)
    );

    // Word that becomes head once the current one pops: the queued one, or a same-edge push.
    assign follow_valid = (count == 2'd2) || push;
    assign follow_word  = (count == 2'd2) ? second : din;

    always_comb begin
        next_state  = state;
        next_idx    = idx;
        next_out_en = out_en;
        next_data   = tx_data;
        next_last   = tx_last;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    next_state  = SEND;
                    next_idx    = 4'd0;
                    next_out_en = 1'b1;
                    next_data   = word_byte(head, 4'd0);
                    next_last   = 1'b0;
                end
            end
            SEND: begin
                if (transfer) begin
                    if (idx == LAST_IDX) begin
`ifdef IOT_TX_CHKSUM_EN
                        next_state = CHK;
                        next_data  = word_xor(head);
                        next_last  = 1'b1;
`else
                        pop = 1'b1;
`endif
                    end else begin
                        next_idx  = idx + 4'd1;
                        next_data = word_byte(head, idx + 4'd1);
                        next_last = !CHK_EN && ((idx + 4'd1) == LAST_IDX);
                    end
                end
            end
`ifdef IOT_TX_CHKSUM_EN
            CHK: begin
                if (transfer) begin
                    pop = 1'b1;
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
        if (pop) begin
            next_idx = 4'd0;
            if (follow_valid) begin
                next_state  = SEND;
                next_out_en = 1'b1;
                next_data   = word_byte(follow_word, 4'd0);
                next_last   = 1'b0;
            end else begin
                next_state  = IDLE;
                next_out_en = 1'b0;
                next_data   = '0;
                next_last   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 4'd0;
            out_en     <= 1'b0;
            tx_data    <= '0;
            tx_last    <= 1'b0;
            words_sent <= 8'd0;
        end else begin
            state   <= next_state;
            idx     <= next_idx;
            out_en  <= next_out_en;
            tx_data <= next_data;
            tx_last <= next_last;
            if (pop) begin
                words_sent <= words_sent + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_iot_tx.sv
// Directed self-checking bench for iot_tx; frame length follows IOT_TX_CHKSUM_EN.
`timescale 1ns/1ps
module tb_iot_tx;
    logic         clk = 1'b0;
    logic         rst;
    logic         din_valid;
    logic [127:0] din;
    logic         din_ready;
    logic         busy;
    logic         out_en;
    logic [7:0]   tx_data;
    logic         tx_last;
    logic [7:0]   words_sent;

    int total = 0;
    int bad   = 0;

`ifdef IOT_TX_CHKSUM_EN
    localparam int FRAME_LEN = 17;
`else
    localparam int FRAME_LEN = 16;
`endif

    localparam logic [127:0] W_SEQ = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] W_A5  = {16{8'hA5}};
    localparam logic [127:0] W_FF0 = 128'h000000000000000000000000000000FF;

    logic [127:0] words [3];
    logic [7:0]   chks  [3];
    logic [8:0]   expq [$];
    logic [8:0]   gotq [$];
    int           n_acc;
    int           oe;
    int           gap;
    logic         prev_oe;
    logic         acc;
    logic         seen_pop;
    logic         seen255;
    logic         ready_after2;
    logic         ready_after_pop;

    iot_tx dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .busy       (busy),
        .out_en     (out_en),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [127:0] d, input logic b);
        rst       = r;
        din_valid = v;
        din       = d;
        busy      = b;
    endtask

    function automatic logic [8:0] exp_byte(input logic [127:0] w, input int k, input logic [7:0] chk);
        if (k < 16) return {(k == FRAME_LEN - 1), w[8*k +: 8]};
        return {1'b1, chk};
    endfunction

    task automatic check_frame(input string tag, input logic [127:0] w, input logic [7:0] chk);
        for (int k = 0; k < FRAME_LEN; k++) begin
            checkOutput({tag, "_byte"}, {22'd0, out_en, tx_last, tx_data}, {22'd0, 1'b1, exp_byte(w, k, chk)});
            tick;
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick;
        tick;
        checkOutput("rst_out_en", out_en, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_tx_last", tx_last, 0);
        checkOutput("rst_words", words_sent, 0);
        checkOutput("rst_ready", din_ready, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        tick;

        // Single word, byte k = k
        checkOutput("t1_ready", din_ready, 1);
        applyStimulus(1'b0, 1'b1, W_SEQ, 1'b0);
        tick;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("t1_latency", out_en, 0);
        tick;
        check_frame("t1", W_SEQ, 8'h00);
        checkOutput("t1_idle_out_en", out_en, 0);
        checkOutput("t1_idle_data", {tx_last, tx_data}, 0);
        checkOutput("t1_words", words_sent, 1);

        // Three words back to back
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick;
        words[0] = W_SEQ; chks[0] = 8'h00;
        words[1] = W_A5;  chks[1] = 8'h00;
        words[2] = W_FF0; chks[2] = 8'hFF;
        expq.delete();
        gotq.delete();
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < FRAME_LEN; k++)
                expq.push_back(exp_byte(words[w], k, chks[w]));
        n_acc = 0; oe = 0; gap = 0; prev_oe = 1'b0; seen_pop = 1'b0;
        ready_after2 = 1'bx; ready_after_pop = 1'bx;
        applyStimulus(1'b0, 1'b1, words[0], 1'b0);
        for (int c = 0; c < 200; c++) begin
            acc = din_valid && din_ready;
            tick;
            if (acc) begin
                n_acc++;
                if (n_acc == 2) ready_after2 = din_ready;
                if (n_acc < 3) din = words[n_acc];
                else din_valid = 1'b0;
            end
            if (out_en) begin
                if (oe > 0 && !prev_oe) gap++;
                oe++;
                gotq.push_back({tx_last, tx_data});
            end
            prev_oe = out_en;
            if (words_sent == 8'd1 && !seen_pop) begin
                seen_pop = 1'b1;
                ready_after_pop = din_ready;
            end
            if (n_acc == 3 && words_sent == 8'd3 && !out_en) break;
        end
        checkOutput("t2_ready_full", ready_after2, 0);
        checkOutput("t2_ready_after_pop", ready_after_pop, 1);
        checkOutput("t2_accepts", n_acc, 3);
        checkOutput("t2_oe_cycles", oe, 3 * FRAME_LEN);
        checkOutput("t2_gaps", gap, 0);
        checkOutput("t2_words", words_sent, 3);
        checkOutput("t2_nbytes", gotq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < gotq.size(); i++)
            checkOutput("t2_stream", gotq[i], expq[i]);

        // busy held for 5 cycles at byte 7
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick;
        applyStimulus(1'b0, 1'b1, W_SEQ, 1'b0);
        tick;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        tick;
        oe = 0;
        for (int k = 0; k < 7; k++) begin
            if (out_en) oe++;
            tick;
        end
        checkOutput("t3_byte7", {out_en, tx_data}, {1'b1, 8'h07});
        busy = 1'b1;
        for (int j = 0; j < 5; j++) begin
            checkOutput("t3_hold", {out_en, tx_last, tx_data}, {1'b1, 1'b0, 8'h07});
            if (out_en) oe++;
            tick;
        end
        busy = 1'b0;
        checkOutput("t3_release", {out_en, tx_data}, {1'b1, 8'h07});
        if (out_en) oe++;
        tick;
        checkOutput("t3_byte8", {out_en, tx_data}, {1'b1, 8'h08});
        for (int c = 0; c < 40 && out_en; c++) begin
            oe++;
            tick;
        end
        checkOutput("t3_cycles", oe, FRAME_LEN + 5);
        checkOutput("t3_words", words_sent, 1);

        // Reset at byte 9 with one word queued
        applyStimulus(1'b0, 1'b1, W_SEQ, 1'b0);
        tick;
        din = W_A5;
        tick;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 9; k++) tick;
        checkOutput("t4_byte9", {out_en, tx_data}, {1'b1, 8'h09});
        applyStimulus(1'b1, 1'b1, W_FF0, 1'b1);
        tick;
        checkOutput("t4_out_en", out_en, 0);
        checkOutput("t4_data", {tx_last, tx_data}, 0);
        checkOutput("t4_ready", din_ready, 1);
        checkOutput("t4_words", words_sent, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        oe = 0;
        for (int c = 0; c < 30; c++) begin
            tick;
            if (out_en) oe++;
        end
        checkOutput("t4_residual", oe, 0);
        checkOutput("t4_words_after", words_sent, 0);

        // 256 words wrap the counter
        n_acc = 0;
        seen255 = 1'b0;
        applyStimulus(1'b0, 1'b1, W_FF0, 1'b0);
        for (int c = 0; c < 6000; c++) begin
            acc = din_valid && din_ready;
            tick;
            if (acc) begin
                n_acc++;
                if (n_acc == 256) din_valid = 1'b0;
            end
            if (words_sent == 8'd255) seen255 = 1'b1;
            if (n_acc == 256 && !out_en) break;
        end
        checkOutput("t5_accepts", n_acc, 256);
        checkOutput("t5_seen255", seen255, 1);
        checkOutput("t5_wrap", words_sent, 0);
        checkOutput("t5_idle", out_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
